// File: rtl/cpu_pause_button_pio.sv
// cpu_pause_button_pio
// Avalon-MM slave input PIO for the pause push-button(s). Raw pins are
// synchronised, debounced per bit, edge-detected into a sticky capture
// register, and reported to the CPU through a masked level interrupt.
//
// Bus semantics: there is no valid/ready handshake. A write happens on
// every clock where chipselect is high and write_n is low, and it is always
// accepted in that cycle. readdata is a zero-latency combinational view of
// the register selected by address, valid whenever address is driven;
// chipselect is not needed for reads. Reads never change any state.
module cpu_pause_button_pio #(
  parameter int unsigned WIDTH           = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned EDGE_TYPE       = 1,
  parameter logic        RESET_LEVEL     = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Counter value at which the new level has been held long enough.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // Idle level of the pins; the pipeline resets here so that releasing
  // reset with the pins idle produces no spurious edge.
  localparam logic [WIDTH-1:0] IDLE     = {WIDTH{RESET_LEVEL}};

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_d;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] rise_bits;
  logic [WIDTH-1:0] fall_bits;
  logic [WIDTH-1:0] event_bits;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] wr_bits;
  logic             wr_en;
  logic             wr_mask;
  logic             wr_edge;

  assign wr_en   = chipselect & ~write_n;
  assign wr_mask = wr_en && (address == ADDR_MASK);
  assign wr_edge = wr_en && (address == ADDR_EDGE);
  assign wr_bits = writedata[WIDTH-1:0];

  // Bits of writedata above WIDTH carry no meaning for this block.
  generate
    if (WIDTH < 32) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^writedata[31:WIDTH];
    end
  endgenerate

  // Two-flop synchroniser per pin; only sync2 is used downstream.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce: accept a new level after DEBOUNCE_CYCLES consecutive
  // cycles of disagreement; any return to the stable level restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= IDLE;
      for (int i = 0; i < int'(WIDTH); i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (sync2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= sync2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Delayed copy of the debounced level for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_d <= IDLE;
    end else begin
      stable_d <= stable;
    end
  end

  assign rise_bits = stable & ~stable_d;
  assign fall_bits = ~stable & stable_d;

  // Select which debounced edges count as button events.
  always_comb begin
    event_bits = '0;
    case (EDGE_TYPE)
      0:       event_bits = rise_bits;
      1:       event_bits = fall_bits;
      default: event_bits = rise_bits | fall_bits;
    endcase
  end

  // Interrupt mask register, loaded by CPU writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask <= '0;
    end else if (wr_mask) begin
      irq_mask <= wr_bits;
    end
  end

  // Sticky edge capture: write-one-to-clear, a new event in the same cycle
  // as its clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      edge_capture <= '0;
    end else if (wr_edge) begin
      edge_capture <= (edge_capture & ~wr_bits) | event_bits;
    end else begin
      edge_capture <= edge_capture | event_bits;
    end
  end

  // Registered level interrupt from any enabled captured edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq <= 1'b0;
    end else begin
      irq <= |(edge_capture & irq_mask);
    end
  end

  // Zero-latency read mux; unused addresses and upper bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = stable;
      ADDR_MASK: readdata[WIDTH-1:0] = irq_mask;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_capture;
      default:   readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cpu_pause_button_pio.sv
// Bench for cpu_pause_button_pio with WIDTH=1, DEBOUNCE_CYCLES=4,
// EDGE_TYPE=1 (falling). Directed scenarios use hand-derived constants;
// the random scenario compares against a window-based reference model:
// the debounced level flips when the last D synchronised samples all
// disagree with it.
module tb_cpu_pause_button_pio;
  localparam int D = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [0:0]  in_port = 1'b1;
  logic [31:0] readdata;
  logic        irq;

  int n_total = 0;
  int n_bad = 0;

  // Reference model state
  logic p1, p2;
  logic m_stable, m_stable_d, m_cap, m_mask, m_irq;
  logic win_q[$];

  cpu_pause_button_pio #(
    .WIDTH(1), .DEBOUNCE_CYCLES(D), .CNT_W(3), .EDGE_TYPE(1), .RESET_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port),
    .readdata(readdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    p1 = 1'b1; p2 = 1'b1;
    m_stable = 1'b1; m_stable_d = 1'b1;
    m_cap = 1'b0; m_mask = 1'b0; m_irq = 1'b0;
    win_q.delete();
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {31'b0, m_stable};
      2'd2:    return {31'b0, m_mask};
      2'd3:    return {31'b0, m_cap};
      default: return 32'd0;
    endcase
  endfunction

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    logic wr, all_diff, n_stable, ev, n_cap, n_mask, n_irq;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      wr = chipselect && !write_n;
      win_q.push_back(p2);
      if (win_q.size() > D) void'(win_q.pop_front());
      all_diff = (win_q.size() == D);
      foreach (win_q[i]) if (win_q[i] == m_stable) all_diff = 1'b0;
      n_stable = all_diff ? ~m_stable : m_stable;
      ev = m_stable_d && !m_stable;
      n_cap = (wr && address == 2'd3) ? (m_cap & ~writedata[0]) : m_cap;
      n_cap = n_cap | ev;
      n_mask = (wr && address == 2'd2) ? writedata[0] : m_mask;
      n_irq = m_cap & m_mask;
      m_stable_d = m_stable;
      m_stable = n_stable;
      m_cap = n_cap;
      m_mask = n_mask;
      m_irq = n_irq;
      p2 = p1;
      p1 = in_port[0];
    end
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    tick();
    chipselect = 1'b0; write_n = 1'b1; writedata = '0;
  endtask

  task automatic test_reset();
    in_port = 1'b1; reset_n = 1'b0; model_reset();
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    address = 2'd0; #1;
    n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL reset_data got=%0h want=1", readdata); end
    address = 2'd3; #1;
    n_total++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_capture got=%0h want=0", readdata); end
    address = 2'd2; #1;
    n_total++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL reset_mask got=%0h want=0", readdata); end
    n_total++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got=%b want=0", irq); end
  endtask

  task automatic test_debounce_latency();
    logic exp_s, exp_c;
    in_port = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_s = (k >= 6) ? 1'b0 : 1'b1;
      exp_c = (k >= 7);
      address = 2'd0; #1;
      n_total++; if (readdata !== {31'b0, exp_s}) begin n_bad++; $display("FAIL latency_stable k=%0d got=%0h want=%0h", k, readdata, exp_s); end
      address = 2'd3; #1;
      n_total++; if (readdata !== {31'b0, exp_c}) begin n_bad++; $display("FAIL latency_capture k=%0d got=%0h want=%0h", k, readdata, exp_c); end
      n_total++; if (irq !== 1'b0) begin n_bad++; $display("FAIL latency_irq_masked k=%0d got=%b want=0", k, irq); end
    end
    wr(2'd3, 32'd1);
    address = 2'd3; #1;
    n_total++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL capture_clear got=%0h want=0", readdata); end
  endtask

  task automatic test_bounce();
    in_port = 1'b1;
    repeat (10) tick();
    address = 2'd0; #1;
    n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL release_stable got=%0h want=1", readdata); end
    address = 2'd3; #1;
    n_total++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL rising_not_captured got=%0h want=0", readdata); end
    for (int c = 0; c < 20; c++) begin
      in_port = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
      address = 2'd0; #1;
      n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL bounce_stable c=%0d got=%0h want=1", c, readdata); end
      address = 2'd3; #1;
      n_total++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL bounce_capture c=%0d got=%0h want=0", c, readdata); end
    end
    in_port = 1'b1;
    repeat (8) tick();
    address = 2'd0; #1;
    n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL after_bounce_stable got=%0h want=1", readdata); end
  endtask

  task automatic test_irq();
    int k;
    bit found;
    wr(2'd2, 32'd1);
    address = 2'd2; #1;
    n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL mask_write got=%0h want=1", readdata); end
    in_port = 1'b0;
    found = 0; k = 0;
    address = 2'd3;
    while (!found && k < 20) begin
      tick(); k++;
      if (readdata[0] === 1'b1) found = 1;
    end
    n_total++; if (!found || k != 7) begin n_bad++; $display("FAIL irq_capture_time got=%0d want=7", k); end
    n_total++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_before got=%b want=0", irq); end
    tick();
    n_total++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_assert got=%b want=1", irq); end
    wr(2'd3, 32'd0);
    address = 2'd3; #1;
    n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL clear_zero_keeps got=%0h want=1", readdata); end
    n_total++; if (irq !== 1'b1) begin n_bad++; $display("FAIL clear_zero_irq got=%b want=1", irq); end
    wr(2'd3, 32'd1);
    address = 2'd3; #1;
    n_total++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL clear_one got=%0h want=0", readdata); end
    tick();
    n_total++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_deassert got=%b want=0", irq); end
  endtask

  task automatic test_set_wins();
    in_port = 1'b1; repeat (10) tick();
    in_port = 1'b0; repeat (8) tick();
    n_total++; if (irq !== 1'b1) begin n_bad++; $display("FAIL setwins_pre_irq got=%b want=1", irq); end
    in_port = 1'b1; repeat (10) tick();
    in_port = 1'b0; repeat (6) tick();
    wr(2'd3, 32'd1);
    address = 2'd3; #1;
    n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL set_wins_capture got=%0h want=1", readdata); end
    n_total++; if (irq !== 1'b1) begin n_bad++; $display("FAIL set_wins_irq0 got=%b want=1", irq); end
    tick();
    n_total++; if (irq !== 1'b1) begin n_bad++; $display("FAIL set_wins_irq1 got=%b want=1", irq); end
  endtask

  task automatic test_reset_mid();
    logic exp_s, exp_c;
    in_port = 1'b1; repeat (10) tick();
    in_port = 1'b0; repeat (4) tick();
    reset_n = 1'b0; model_reset();
    address = 2'd0; #1;
    n_total++; if (readdata !== 32'd1) begin n_bad++; $display("FAIL midreset_stable got=%0h want=1", readdata); end
    address = 2'd3; #1;
    n_total++; if (readdata !== 32'd0) begin n_bad++; $display("FAIL midreset_capture got=%0h want=0", readdata); end
    n_total++; if (irq !== 1'b0) begin n_bad++; $display("FAIL midreset_irq got=%b want=0", irq); end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_s = (k >= 6) ? 1'b0 : 1'b1;
      exp_c = (k >= 7);
      address = 2'd0; #1;
      n_total++; if (readdata !== {31'b0, exp_s}) begin n_bad++; $display("FAIL postreset_stable k=%0d got=%0h want=%0h", k, readdata, exp_s); end
      address = 2'd3; #1;
      n_total++; if (readdata !== {31'b0, exp_c}) begin n_bad++; $display("FAIL postreset_capture k=%0d got=%0h want=%0h", k, readdata, exp_c); end
    end
    n_total++; if (irq !== 1'b0) begin n_bad++; $display("FAIL postreset_irq got=%b want=0", irq); end
  endtask

  task automatic test_random();
    int hold = 0;
    logic [31:0] exp_rd;
    for (int n = 0; n < 800; n++) begin
      if (hold == 0) begin
        in_port = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 8);
      end
      hold--;
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1'($urandom_range(0, 3) != 0);
        write_n = 1'b0;
        address = 2'($urandom_range(0, 3));
        writedata = $urandom;
      end else begin
        chipselect = 1'b0; write_n = 1'b1;
      end
      tick();
      chipselect = 1'b0; write_n = 1'b1;
      address = 2'($urandom_range(0, 3)); #1;
      exp_rd = model_read(address);
      n_total++; if (readdata !== exp_rd) begin n_bad++; $display("FAIL random_read n=%0d addr=%0d got=%0h want=%0h", n, address, readdata, exp_rd); end
      n_total++; if (irq !== m_irq) begin n_bad++; $display("FAIL random_irq n=%0d got=%b want=%b", n, irq, m_irq); end
    end
  endtask

  initial begin
    test_reset();
    test_debounce_latency();
    test_bounce();
    test_irq();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
